data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/alu.sv | 64 ++++++
 rtl/data_path.sv | 102 ++++++++++
 tb/tb_data_path.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU datapath and control unit: ALU ops, bus selects, CCR bit layout.
// ALU ops 110/111 are only implemented when DATA_PATH_ALU_EXT_EN is defined.
package cpu_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluInc = 3'b100,
        AluDec = 3'b101,
        AluXor = 3'b110,
        AluShl = 3'b111
    } alu_sel_e;

    typedef enum logic [1:0] {
        Bus1Pc   = 2'b00,
        Bus1A    = 2'b01,
        Bus1B    = 2'b10,
        Bus1Zero = 2'b11
    } bus1_sel_e;

    typedef enum logic [1:0] {
        Bus2Alu   = 2'b00,
        Bus2Bus1  = 2'b01,
        Bus2Mem   = 2'b10,
        Bus2Zero  = 2'b11
    } bus2_sel_e;

    localparam int unsigned CcrN = 3;
    localparam int unsigned CcrZ = 2;
    localparam int unsigned CcrV = 1;
    localparam int unsigned CcrC = 0;

    function automatic logic [3:0] pack_nzvc(input logic n, input logic z,
                                             input logic v, input logic c);
        logic [3:0] f;
        f       = '0;
        f[CcrN] = n;
        f[CcrZ] = z;
        f[CcrV] = v;
        f[CcrC] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU with NZVC flags; X comes from Bus1, Y from the B register.
// Define DATA_PATH_ALU_EXT_EN to enable XOR (110) and shift-left (111).
module alu
    import cpu_pkg::*;
(
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic [2:0] ALU_Sel,
    output logic [7:0] result,
    output logic [3:0] NZVC
);

    logic [8:0] wide;
    logic       v;
    logic       c;

    always_comb begin
        wide   = '0;
        result = '0;
        v      = 1'b0;
        c      = 1'b0;
        unique case (ALU_Sel)
            AluAdd: begin
                wide   = {1'b0, X} + {1'b0, Y};
                result = wide[7:0];
                c      = wide[8];
                v      = (X[7] == Y[7]) && (result[7] != X[7]);
            end
            AluSub: begin
                // Bit 8 of the 9-bit difference is the borrow
                wide   = {1'b0, X} - {1'b0, Y};
                result = wide[7:0];
                c      = wide[8];
                v      = (X[7] != Y[7]) && (result[7] != X[7]);
            end
            AluAnd: result = X & Y;
            AluOr:  result = X | Y;
            AluInc: begin
                wide   = {1'b0, X} + 9'd1;
                result = wide[7:0];
                c      = wide[8];
                v      = ~X[7] & result[7];
            end
            AluDec: begin
                wide   = {1'b0, X} - 9'd1;
                result = wide[7:0];
                c      = wide[8];
                v      = X[7] & ~result[7];
            end
`ifdef DATA_PATH_ALU_EXT_EN
            AluXor: result = X ^ Y;
            AluShl: begin
                result = {X[6:0], 1'b0};
                c      = X[7];
                v      = X[7] ^ X[6];
            end
`endif
            default: result = '0;
        endcase
    end

    assign NZVC = pack_nzvc(result[7], result == 8'h00, v, c);

endmodule

// File: rtl/data_path.sv
// 8-bit CPU datapath: PC/IR/MAR/A/B/CCR registers around a two-bus structure and the ALU.
// Optional ALU ops are enabled by DATA_PATH_ALU_EXT_EN (see alu).
module data_path
    import cpu_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       IR_Load,
    input  logic       MAR_Load,
    input  logic       PC_Load,
    input  logic       PC_Inc,
    input  logic       A_Load,
    input  logic       B_Load,
    input  logic       CCR_Load,
    input  logic [2:0] ALU_Sel,
    input  logic [1:0] Bus1_Sel,
    input  logic [1:0] Bus2_Sel,
    input  logic [7:0] from_memory,
    output logic [7:0] address,
    output logic [7:0] to_memory,
    output logic [7:0] IR,
    output logic [3:0] CCR_Result
);

    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] mar_q, mar_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] ccr_q, ccr_d;

    logic [7:0] bus1;
    logic [7:0] bus2;
    logic [7:0] alu_result;
    logic [3:0] alu_nzvc;

    always_comb begin
        bus1 = '0;
        unique case (Bus1_Sel)
            Bus1Pc:  bus1 = pc_q;
            Bus1A:   bus1 = a_q;
            Bus1B:   bus1 = b_q;
            default: bus1 = '0;
        endcase
    end

    alu u_alu (
        .X       (bus1),
        .Y       (b_q),
        .ALU_Sel (ALU_Sel),
        .result  (alu_result),
        .NZVC    (alu_nzvc)
    );

    always_comb begin
        bus2 = '0;
        unique case (Bus2_Sel)
            Bus2Alu:  bus2 = alu_result;
            Bus2Bus1: bus2 = bus1;
            Bus2Mem:  bus2 = from_memory;
            default:  bus2 = '0;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = IR_Load  ? bus2 : ir_q;
        mar_d = MAR_Load ? bus2 : mar_q;
        a_d   = A_Load   ? bus2 : a_q;
        b_d   = B_Load   ? bus2 : b_q;
        ccr_d = CCR_Load ? alu_nzvc : ccr_q;
        if (PC_Load) begin
            pc_d = bus2;
        end else if (PC_Inc) begin
            pc_d = pc_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ccr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign address    = mar_q;
    assign IR         = ir_q;
    assign CCR_Result = ccr_q;
    assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus random cycles against an
// arithmetic reference model.
module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, IR;
    logic [3:0] CCR_Result;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [7:0] m_pc, m_ir, m_mar, m_a, m_b;
    logic [3:0] m_ccr;

    data_path dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IR_Load     (IR_Load),
        .MAR_Load    (MAR_Load),
        .PC_Load     (PC_Load),
        .PC_Inc      (PC_Inc),
        .A_Load      (A_Load),
        .B_Load      (B_Load),
        .CCR_Load    (CCR_Load),
        .ALU_Sel     (ALU_Sel),
        .Bus1_Sel    (Bus1_Sel),
        .Bus2_Sel    (Bus2_Sel),
        .from_memory (from_memory),
        .address     (address),
        .to_memory   (to_memory),
        .IR          (IR),
        .CCR_Result  (CCR_Result)
    );

    always #5 Clk = ~Clk;

    function automatic int to_signed(input logic [7:0] x);
        return (int'(x) > 127) ? int'(x) - 256 : int'(x);
    endfunction

    // ALU behaviour from plain integer arithmetic; flags {N,Z,V,C}
    task automatic alu_ref(input logic [2:0] sel, input logic [7:0] x, input logic [7:0] y,
                           output logic [7:0] res, output logic [3:0] f);
        int s, sv;
        logic v, c;
        s = 0; sv = 0; v = 1'b0; c = 1'b0; res = 8'h00;
        case (sel)
            3'd0: begin s = int'(x) + int'(y); sv = to_signed(x) + to_signed(y);
                        res = 8'(s); c = (s > 255); v = (sv > 127 || sv < -128); end
            3'd1: begin s = int'(x) - int'(y); sv = to_signed(x) - to_signed(y);
                        res = 8'(s); c = (s < 0); v = (sv > 127 || sv < -128); end
            3'd2: res = x & y;
            3'd3: res = x | y;
            3'd4: begin s = int'(x) + 1; sv = to_signed(x) + 1;
                        res = 8'(s); c = (s > 255); v = (sv > 127); end
            3'd5: begin s = int'(x) - 1; sv = to_signed(x) - 1;
                        res = 8'(s); c = (s < 0); v = (sv < -128); end
`ifdef DATA_PATH_ALU_EXT_EN
            3'd6: res = x ^ y;
            3'd7: begin s = int'(x) * 2; sv = to_signed(x) * 2;
                        res = 8'(s); c = (s > 255); v = (sv > 127 || sv < -128); end
`endif
            default: res = 8'h00;
        endcase
        f = {res > 8'd127, res == 8'h00, v, c};
    endtask

    function automatic logic [7:0] model_bus1();
        case (Bus1_Sel)
            2'd0: return m_pc;
            2'd1: return m_a;
            2'd2: return m_b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mar = 0; m_a = 0; m_b = 0; m_ccr = 0;
    endtask

    // Advance one clock; the model applies the same inputs in parallel.
    task automatic tick();
        logic [7:0] b1, b2, r;
        logic [3:0] f;
        b1 = model_bus1();
        alu_ref(ALU_Sel, b1, m_b, r, f);
        case (Bus2_Sel)
            2'd0: b2 = r;
            2'd1: b2 = b1;
            2'd2: b2 = from_memory;
            default: b2 = 8'h00;
        endcase
        @(posedge Clk);
        #1;
        if (PC_Load) m_pc = b2;
        else if (PC_Inc) m_pc = m_pc + 8'd1;
        if (IR_Load)  m_ir  = b2;
        if (MAR_Load) m_mar = b2;
        if (A_Load)   m_a   = b2;
        if (B_Load)   m_b   = b2;
        if (CCR_Load) m_ccr = f;
    endtask

    task automatic idle();
        IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0;
        A_Load = 0; B_Load = 0; CCR_Load = 0;
        ALU_Sel = 3'd0; Bus1_Sel = 2'd0; Bus2_Sel = 2'd0; from_memory = 8'h00;
    endtask

    // which: 0=A 1=B 2=PC, loaded from memory data
    task automatic set_reg(input int which, input logic [7:0] val);
        idle();
        Bus2_Sel = 2'd2;
        from_memory = val;
        case (which)
            0: A_Load = 1;
            1: B_Load = 1;
            default: PC_Load = 1;
        endcase
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        #3;
        n_checks++;
        if (address !== 8'h00) begin n_fail++;
            $display("FAIL reset_address got=%h exp=00", address); end
        n_checks++;
        if (IR !== 8'h00) begin n_fail++; $display("FAIL reset_ir got=%h exp=00", IR); end
        n_checks++;
        if (CCR_Result !== 4'h0) begin n_fail++;
            $display("FAIL reset_ccr got=%h exp=0", CCR_Result); end
        n_checks++;
        if (to_memory !== 8'h00) begin n_fail++;
            $display("FAIL reset_pc got=%h exp=00", to_memory); end
        model_reset();
        #4 Reset = 1'b0;
    endtask

    task automatic test_fetch();
        set_reg(2, 8'h10);
        Bus1_Sel = 2'd0; Bus2_Sel = 2'd1; MAR_Load = 1; PC_Inc = 1;
        tick();
        idle();
        n_checks++;
        if (address !== 8'h10) begin n_fail++;
            $display("FAIL fetch_mar got=%h exp=10", address); end
        n_checks++;
        if (to_memory !== 8'h11) begin n_fail++;
            $display("FAIL fetch_pc_inc got=%h exp=11", to_memory); end
        Bus2_Sel = 2'd2; IR_Load = 1; from_memory = 8'h86;
        tick();
        idle();
        n_checks++;
        if (IR !== 8'h86) begin n_fail++; $display("FAIL fetch_ir got=%h exp=86", IR); end
    endtask

    task automatic alu_to_a(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [7:0] exp_a, input logic [3:0] exp_f);
        set_reg(0, a);
        set_reg(1, b);
        ALU_Sel = op; Bus1_Sel = 2'd1; Bus2_Sel = 2'd0; A_Load = 1; CCR_Load = 1;
        tick();
        idle();
        Bus1_Sel = 2'd1;
        #1;
        n_checks++;
        if (to_memory !== exp_a) begin n_fail++;
            $display("FAIL alu_op%0d_result got=%h exp=%h", op, to_memory, exp_a); end
        n_checks++;
        if (CCR_Result !== exp_f) begin n_fail++;
            $display("FAIL alu_op%0d_ccr got=%b exp=%b", op, CCR_Result, exp_f); end
    endtask

    task automatic test_alu();
        alu_to_a(8'h7F, 8'h01, 3'd0, 8'h80, 4'b1010);
        alu_to_a(8'h00, 8'h01, 3'd1, 8'hFF, 4'b1001);
`ifdef DATA_PATH_ALU_EXT_EN
        alu_to_a(8'hF0, 8'hFF, 3'd6, 8'h0F, 4'b0000);
`else
        alu_to_a(8'hF0, 8'hFF, 3'd6, 8'h00, 4'b0100);
`endif
    endtask

    task automatic test_pc_wrap();
        set_reg(2, 8'hFF);
        PC_Inc = 1;
        tick();
        idle();
        #1;
        n_checks++;
        if (to_memory !== 8'h00) begin n_fail++;
            $display("FAIL pc_wrap got=%h exp=00", to_memory); end
        PC_Load = 1; PC_Inc = 1; Bus2_Sel = 2'd2; from_memory = 8'h40;
        tick();
        idle();
        #1;
        n_checks++;
        if (to_memory !== 8'h40) begin n_fail++;
            $display("FAIL pc_load_priority got=%h exp=40", to_memory); end
    endtask

    task automatic test_back_to_back();
        set_reg(0, 8'h10);
        set_reg(1, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            ALU_Sel = 3'd0; Bus1_Sel = 2'd1; Bus2_Sel = 2'd0; A_Load = 1;
            tick();
            #1;
            n_checks++;
            if (to_memory !== 8'(8'h10 + 3 * i)) begin n_fail++;
                $display("FAIL accumulate_%0d got=%h exp=%h", i, to_memory, 8'(8'h10 + 3 * i));
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        set_reg(0, 8'h55);
        set_reg(2, 8'h33);
        Bus2_Sel = 2'd2; from_memory = 8'h77; IR_Load = 1; MAR_Load = 1;
        ALU_Sel = 3'd5; Bus1_Sel = 2'd1; CCR_Load = 1;
        tick();
        idle();
        Bus2_Sel = 2'd2; from_memory = 8'hAA;
        IR_Load = 1; MAR_Load = 1; PC_Load = 1; A_Load = 1;
        #2 Reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (address !== 8'h00) begin n_fail++;
            $display("FAIL midrst_mar got=%h exp=00", address); end
        n_checks++;
        if (IR !== 8'h00) begin n_fail++; $display("FAIL midrst_ir got=%h exp=00", IR); end
        n_checks++;
        if (CCR_Result !== 4'h0) begin n_fail++;
            $display("FAIL midrst_ccr got=%h exp=0", CCR_Result); end
        Bus1_Sel = 2'd1;
        #1;
        n_checks++;
        if (to_memory !== 8'h00) begin n_fail++;
            $display("FAIL midrst_a got=%h exp=00", to_memory); end
        Bus1_Sel = 2'd0;
        #1;
        n_checks++;
        if (to_memory !== 8'h00) begin n_fail++;
            $display("FAIL midrst_pc got=%h exp=00", to_memory); end
        #1 Reset = 1'b0;
        tick();
        n_checks++;
        if (IR !== 8'hAA || address !== 8'hAA || to_memory !== 8'hAA) begin n_fail++;
            $display("FAIL post_reset_load got ir=%h mar=%h pc=%h exp=aa", IR, address,
                     to_memory);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            IR_Load = 1'($urandom); MAR_Load = 1'($urandom); PC_Load = 1'($urandom);
            PC_Inc = 1'($urandom); A_Load = 1'($urandom); B_Load = 1'($urandom);
            CCR_Load = 1'($urandom);
            ALU_Sel = 3'($urandom); Bus1_Sel = 2'($urandom); Bus2_Sel = 2'($urandom);
            from_memory = 8'($urandom);
            #1;
            n_checks++;
            if (to_memory !== model_bus1()) begin n_fail++;
                $display("FAIL rand_bus1 i=%0d got=%h exp=%h", i, to_memory, model_bus1());
            end
            tick();
            n_checks++;
            if (address !== m_mar || IR !== m_ir || CCR_Result !== m_ccr) begin n_fail++;
                $display("FAIL rand_regs i=%0d got mar=%h ir=%h ccr=%h exp mar=%h ir=%h ccr=%h",
                         i, address, IR, CCR_Result, m_mar, m_ir, m_ccr);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_fetch();
        test_alu();
        test_pc_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
